// File: rtl/decoder_seq_pkg.sv
// Shared encodings for the sequenced decoder: operating modes, sweep states
// and the step-counter width helper.
package decoder_seq_pkg;

  typedef enum logic [1:0] {
    MODE_DIRECT = 2'b00,
    MODE_SCAN   = 2'b01,
    MODE_SWEEP  = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SWEEP = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  // Counter must be able to hold every value 0..STEP_DIV.
  function automatic int step_cnt_w(input int div);
    return $clog2(div + 1);
  endfunction

endpackage

// File: rtl/decoder_tick_gen.sv
// Step divider: emits one tick every STEP_DIV cycles in which run is high.
// clr restarts the count, and a cycle with both clr and run counts as the first.
module decoder_tick_gen
  import decoder_seq_pkg::*;
#(
  parameter int STEP_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clr,
  output logic tick
);

  localparam int CW = step_cnt_w(STEP_DIV);
  localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_base;
  logic [CW-1:0] w_cnt_nxt;

  always_comb begin
    w_base    = clr ? '0 : r_cnt;
    tick      = run && (w_base == LAST);
    w_cnt_nxt = w_base;
    if (run) begin
      w_cnt_nxt = tick ? '0 : w_base + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

endmodule

// File: rtl/decoder_seq.sv
// Sequenced one-hot decoder: direct select, free-running scan, or a one-shot
// sweep through every output with busy/done handshake.
module decoder_seq
  import decoder_seq_pkg::*;
#(
  parameter int N        = 3,
  parameter int OUT_W    = 2**N,
  parameter int STEP_DIV = 4,
  parameter bit ACT_LOW  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [N-1:0]     sel,
  input  logic             start,
  output logic [OUT_W-1:0] dec_out,
  output logic [N-1:0]     idx,
  output logic             busy,
  output logic             done
);

  localparam logic [N-1:0] IDX_LAST = N'(OUT_W - 1);

  mode_e            w_mode;
  mode_e            r_mode_q;
  state_e           r_state;
  state_e           w_state_nxt;
  logic [N-1:0]     r_idx;
  logic [N-1:0]     w_idx_nxt;
  logic [OUT_W-1:0] r_dec;
  logic [OUT_W-1:0] w_dec_nxt;
  logic             w_mode_chg;
  logic             w_start_acc;
  logic             w_run;
  logic             w_clr;
  logic             w_tick;
  logic             w_at_last;

  assign w_mode      = mode_e'(mode);
  assign w_mode_chg  = en && (w_mode != r_mode_q);
  assign w_start_acc = en && (w_mode == MODE_SWEEP) && (r_state == ST_IDLE) && start;
  assign w_at_last   = (r_idx == IDX_LAST);

  // Counter runs only while stepping; DIRECT pins it to zero.
  assign w_run = en && ((w_mode == MODE_SCAN) ||
                        ((w_mode == MODE_SWEEP) && (r_state == ST_SWEEP)));
  assign w_clr = w_mode_chg || w_start_acc || (en && (w_mode == MODE_DIRECT));

  decoder_tick_gen #(
    .STEP_DIV (STEP_DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (w_run),
    .clr   (w_clr),
    .tick  (w_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (en) begin
      case (r_state)
        ST_IDLE:  if (w_start_acc) w_state_nxt = ST_SWEEP;
        ST_SWEEP: begin
          if (w_mode != MODE_SWEEP) begin
            w_state_nxt = ST_IDLE;
          end else if (w_tick && w_at_last) begin
            w_state_nxt = ST_DONE;
          end
        end
        ST_DONE:  w_state_nxt = ST_IDLE;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (r_state == ST_SWEEP);
    done = (r_state == ST_DONE);
  end

  always_comb begin
    w_idx_nxt = r_idx;
    if (en) begin
      case (w_mode)
        MODE_DIRECT: w_idx_nxt = sel;
        MODE_SCAN:   if (w_tick) w_idx_nxt = r_idx + N'(1);
        MODE_SWEEP: begin
          if (w_start_acc) begin
            w_idx_nxt = '0;
          end else if ((r_state == ST_SWEEP) && w_tick && !w_at_last) begin
            w_idx_nxt = r_idx + N'(1);
          end
        end
        default:     w_idx_nxt = r_idx;
      endcase
    end
  end

  // Decode from the next index so dec_out and idx always agree.
  always_comb begin
    w_dec_nxt = '0;
    for (int k = 0; k < OUT_W; k++) begin
      w_dec_nxt[k] = (w_idx_nxt == N'(k));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx    <= '0;
      r_dec    <= '0;
      r_mode_q <= MODE_DIRECT;
    end else begin
      r_idx <= w_idx_nxt;
      r_dec <= en ? w_dec_nxt : '0;
      if (en) begin
        r_mode_q <= w_mode;
      end
    end
  end

  assign idx     = r_idx;
  assign dec_out = r_dec ^ {OUT_W{ACT_LOW}};

endmodule

// File: tb/tb_decoder_seq.sv
// Directed bench for decoder_seq: three instances cover direct/scan/pause,
// sweep with abort, and active-low output with reset mid-sweep.
module tb_decoder_seq;
  import decoder_seq_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Instance A: N=3, STEP_DIV=4
  logic       rst_n_a, en_a, start_a, busy_a, done_a;
  logic [1:0] mode_a;
  logic [2:0] sel_a, idx_a;
  logic [7:0] dec_a;

  // Instance B: N=2, STEP_DIV=1
  logic       rst_n_b, en_b, start_b, busy_b, done_b;
  logic [1:0] mode_b;
  logic [1:0] sel_b, idx_b;
  logic [3:0] dec_b;

  // Instance C: N=2, STEP_DIV=2, ACT_LOW=1
  logic       rst_n_c, en_c, start_c, busy_c, done_c;
  logic [1:0] mode_c;
  logic [1:0] sel_c, idx_c;
  logic [3:0] dec_c;

  decoder_seq #(.N(3), .STEP_DIV(4), .ACT_LOW(1'b0)) u_a (
    .clk(clk), .rst_n(rst_n_a), .en(en_a), .mode(mode_a), .sel(sel_a),
    .start(start_a), .dec_out(dec_a), .idx(idx_a), .busy(busy_a), .done(done_a)
  );

  decoder_seq #(.N(2), .STEP_DIV(1), .ACT_LOW(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n_b), .en(en_b), .mode(mode_b), .sel(sel_b),
    .start(start_b), .dec_out(dec_b), .idx(idx_b), .busy(busy_b), .done(done_b)
  );

  decoder_seq #(.N(2), .STEP_DIV(2), .ACT_LOW(1'b1)) u_c (
    .clk(clk), .rst_n(rst_n_c), .en(en_c), .mode(mode_c), .sel(sel_c),
    .start(start_c), .dec_out(dec_c), .idx(idx_c), .busy(busy_c), .done(done_c)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] e_dec8;
    logic [2:0] e_idx3;

    rst_n_a = 1'b0; en_a = 1'b0; mode_a = MODE_DIRECT; sel_a = '0; start_a = 1'b0;
    rst_n_b = 1'b0; en_b = 1'b0; mode_b = MODE_DIRECT; sel_b = '0; start_b = 1'b0;
    rst_n_c = 1'b0; en_c = 1'b0; mode_c = MODE_DIRECT; sel_c = '0; start_c = 1'b0;

    #2;
    chk("rst_idx_a",  32'(idx_a),  0);
    chk("rst_dec_a",  32'(dec_a),  0);
    chk("rst_busy_a", 32'(busy_a), 0);
    chk("rst_done_a", 32'(done_a), 0);
    chk("rst_dec_c",  32'(dec_c),  32'hF);
    chk("rst_busy_c", 32'(busy_c), 0);

    #10;
    rst_n_a = 1'b1;

    // DIRECT: sel=5 -> one cycle later idx=5, bit 5 set
    en_a = 1'b1; mode_a = MODE_DIRECT; sel_a = 3'd5;
    step();
    chk("direct5_idx", 32'(idx_a), 5);
    chk("direct5_dec", 32'(dec_a), 32'h20);
    chk("direct_busy", 32'(busy_a), 0);
    sel_a = 3'd0;
    step();
    chk("direct0_idx", 32'(idx_a), 0);
    chk("direct0_dec", 32'(dec_a), 32'h01);
    sel_a = 3'd7;
    step();
    chk("direct7_idx", 32'(idx_a), 7);
    chk("direct7_dec", 32'(dec_a), 32'h80);

    // SCAN from reset: idx advances on every 4th edge, wraps after 7
    rst_n_a = 1'b0;
    #2;
    chk("scan_rst_idx", 32'(idx_a), 0);
    chk("scan_rst_dec", 32'(dec_a), 0);
    mode_a = MODE_SCAN;
    rst_n_a = 1'b1;
    for (int k = 1; k <= 38; k++) begin
      step();
      e_idx3 = 3'((k / 4) % 8);
      e_dec8 = 8'd1 << e_idx3;
      chk($sformatf("scan_idx_k%0d", k), 32'(idx_a), 32'(e_idx3));
      chk($sformatf("scan_dec_k%0d", k), 32'(dec_a), 32'(e_dec8));
    end

    // Pause for 10 cycles at idx=1 with two steps already counted
    en_a = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      chk($sformatf("pause_dec_%0d", k), 32'(dec_a), 0);
      chk($sformatf("pause_idx_%0d", k), 32'(idx_a), 1);
    end
    en_a = 1'b1;
    step();
    chk("resume1_idx", 32'(idx_a), 1);
    chk("resume1_dec", 32'(dec_a), 32'h02);
    step();
    chk("resume2_idx", 32'(idx_a), 2);
    chk("resume2_dec", 32'(dec_a), 32'h04);

    // Instance B: start outside SWEEP mode is ignored
    rst_n_b = 1'b1;
    en_b = 1'b1; mode_b = MODE_HOLD; start_b = 1'b1;
    step();
    chk("hold_start_busy", 32'(busy_b), 0);
    chk("hold_start_idx",  32'(idx_b),  0);
    chk("hold_start_dec",  32'(dec_b),  32'h1);
    mode_b = MODE_SWEEP; start_b = 1'b0;
    step();
    chk("sweep_idle_busy", 32'(busy_b), 0);

    // Full sweep at STEP_DIV=1 with a second start while busy
    start_b = 1'b1;
    step();
    chk("sw0_busy", 32'(busy_b), 1);
    chk("sw0_idx",  32'(idx_b),  0);
    chk("sw0_done", 32'(done_b), 0);
    chk("sw0_dec",  32'(dec_b),  32'h1);
    start_b = 1'b0;
    step();
    chk("sw1_busy", 32'(busy_b), 1);
    chk("sw1_idx",  32'(idx_b),  1);
    chk("sw1_dec",  32'(dec_b),  32'h2);
    start_b = 1'b1;
    step();
    chk("sw2_busy", 32'(busy_b), 1);
    chk("sw2_idx",  32'(idx_b),  2);
    chk("sw2_dec",  32'(dec_b),  32'h4);
    start_b = 1'b0;
    step();
    chk("sw3_busy", 32'(busy_b), 1);
    chk("sw3_idx",  32'(idx_b),  3);
    chk("sw3_done", 32'(done_b), 0);
    step();
    chk("swd_busy", 32'(busy_b), 0);
    chk("swd_done", 32'(done_b), 1);
    chk("swd_idx",  32'(idx_b),  3);
    step();
    chk("swi_busy", 32'(busy_b), 0);
    chk("swi_done", 32'(done_b), 0);
    chk("swi_idx",  32'(idx_b),  3);
    chk("swi_dec",  32'(dec_b),  32'h8);

    // Sweep aborted by switching to HOLD while idx=3
    start_b = 1'b1;
    step();
    chk("ab0_busy", 32'(busy_b), 1);
    chk("ab0_idx",  32'(idx_b),  0);
    start_b = 1'b0;
    step();
    step();
    step();
    chk("ab3_idx",  32'(idx_b),  3);
    chk("ab3_busy", 32'(busy_b), 1);
    mode_b = MODE_HOLD;
    step();
    chk("ab_busy",  32'(busy_b), 0);
    chk("ab_done",  32'(done_b), 0);
    chk("ab_idx",   32'(idx_b),  3);
    step();
    chk("ab2_done", 32'(done_b), 0);
    chk("ab2_idx",  32'(idx_b),  3);
    chk("ab2_dec",  32'(dec_b),  32'h8);

    // Instance C: active-low output, reset pulsed between edges mid-sweep
    rst_n_c = 1'b1;
    en_c = 1'b1; mode_c = MODE_SWEEP;
    step();
    chk("c_idle_dec",  32'(dec_c),  32'hE);
    chk("c_idle_busy", 32'(busy_c), 0);
    start_c = 1'b1;
    step();
    chk("c_sw0_busy", 32'(busy_c), 1);
    chk("c_sw0_dec",  32'(dec_c),  32'hE);
    start_c = 1'b0;
    step();
    chk("c_sw0b_idx", 32'(idx_c), 0);
    step();
    chk("c_sw1_idx",  32'(idx_c), 1);
    chk("c_sw1_dec",  32'(dec_c), 32'hD);
    chk("c_sw1_busy", 32'(busy_c), 1);
    #3;
    rst_n_c = 1'b0;
    #1;
    chk("c_arst_dec",  32'(dec_c),  32'hF);
    chk("c_arst_busy", 32'(busy_c), 0);
    chk("c_arst_done", 32'(done_c), 0);
    chk("c_arst_idx",  32'(idx_c),  0);
    step();
    chk("c_inrst_dec",  32'(dec_c),  32'hF);
    chk("c_inrst_busy", 32'(busy_c), 0);
    rst_n_c = 1'b1;
    step();
    chk("c_post_done", 32'(done_c), 0);
    chk("c_post_busy", 32'(busy_c), 0);
    chk("c_post_dec",  32'(dec_c),  32'hE);
    step();
    chk("c_post2_done", 32'(done_c), 0);
    chk("c_post2_busy", 32'(busy_c), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/decoder_seq.md
DECODER_SEQ -- requirements
Module: decoder_seq

Interface
REQ-001 The block SHALL have parameter N, default 3: select width; legal range 1..6.
REQ-002 The block SHALL have parameter OUT_W, default 2**N: decoded output width; derived, not overridden.
REQ-003 The block SHALL have parameter STEP_DIV, default 4: clock cycles per scan/sweep step; legal range 1..65535.
REQ-004 The block SHALL have parameter ACT_LOW, default 0: 1 inverts every bit of dec_out, including the reset value.
REQ-005 The block SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-007 The block SHALL have port en, input, 1: enable; low forces dec_out inactive and pauses all counters.
REQ-008 The block SHALL have port mode, input, 2: 00 DIRECT, 01 SCAN, 10 SWEEP, 11 HOLD.
REQ-009 The block SHALL have port sel, input, N: select code used in DIRECT mode.
REQ-010 The block SHALL have port start, input, 1: single-cycle request that begins a SWEEP.
REQ-011 The block SHALL have port dec_out, output, OUT_W: one-hot decoded output, registered.
REQ-012 The block SHALL have port idx, output, N: currently decoded index, registered.
REQ-013 The block SHALL have port busy, output, 1: high while a SWEEP is in progress.
REQ-014 The block SHALL have port done, output, 1: one-cycle pulse when a SWEEP completes.

Function
REQ-015 When en=1, dec_out bit k SHALL be active exactly when idx==k, and all other bits SHALL be inactive; dec_out SHALL never have more than one bit active.
REQ-016 In DIRECT mode, idx SHALL take the value of sel with 1-cycle latency, and the step counter SHALL be held at 0.
REQ-017 In SCAN mode, idx SHALL increment every STEP_DIV enabled cycles and SHALL wrap from OUT_W-1 to 0.
REQ-018 The state machine SHALL have states IDLE, SWEEP and DONE; SWEEP SHALL be entered from IDLE only when mode=10, en=1 and start=1.
REQ-019 On entry to SWEEP, idx SHALL be set to 0 and busy SHALL be set to 1 on the following edge; idx SHALL advance every STEP_DIV enabled cycles.
REQ-020 The SWEEP-to-DONE transition SHALL occur after idx=OUT_W-1 has been held for STEP_DIV cycles; in DONE, done=1 and busy=0 for one cycle, then the state SHALL return to IDLE with idx held at OUT_W-1.
REQ-021 A start received while busy=1 SHALL be ignored.
REQ-022 A start received in any mode other than SWEEP SHALL be ignored.
REQ-023 Any change of mode away from SWEEP while busy=1 SHALL abort the sweep: IDLE state next edge, busy=0, no done pulse.
REQ-024 In HOLD mode, idx and the step counter SHALL freeze and dec_out SHALL keep its value.
REQ-025 While en=0, dec_out SHALL be inactive, and idx, the step counter and the state SHALL freeze; when en returns to 1, operation SHALL resume from the frozen point.
REQ-026 With STEP_DIV=1, idx SHALL advance every cycle in SCAN and SWEEP; a full sweep SHALL then last OUT_W cycles of busy.
REQ-027 The step counter SHALL be ceil(log2(STEP_DIV+1)) bits wide and SHALL reset to 0 on every idx advance and on every mode change.

Reset
REQ-028 While rst_n=0, regardless of clk: idx=0, step counter=0, state=IDLE, busy=0, done=0, dec_out all inactive (all 0 when ACT_LOW=0, all 1 when ACT_LOW=1).
REQ-029 Reset asserted mid-SWEEP SHALL abort the sweep with no done pulse; deassertion SHALL take effect synchronously to clk.

Structure
REQ-030 The mode encodings (DIRECT/SCAN/SWEEP/HOLD) and state encodings SHALL be defined once in the shared decoder package and used by both RTL and bench.
REQ-031 The step-divider SHALL be a sub-module, decoder_tick_gen (ports clk, rst_n, run, clr, tick), parametrised by STEP_DIV.
REQ-032 The one-hot generation SHALL be a parametrised loop over OUT_W, not a hand-enumerated list of AND gates.

Verification
REQ-033 Bench SHALL cover: N=3, DIRECT, sel=5 at cycle t -> dec_out=8'b0010_0000, idx=5 at t+1.
REQ-034 Bench SHALL cover: N=3, STEP_DIV=4, SCAN from reset -> idx steps 0..7,0 with 4-cycle spacing, one-hot on every cycle.
REQ-035 Bench SHALL cover: N=2, STEP_DIV=1, SWEEP plus start pulse -> busy for 4 cycles, idx 0,1,2,3, done for 1 cycle, a second start during busy ignored.
REQ-036 Bench SHALL cover: SWEEP aborted by mode change to HOLD at idx=3 -> busy=0 next cycle, no done, idx stays 3.
REQ-037 Bench SHALL cover: en=0 for 10 cycles mid-SCAN -> dec_out=0 throughout, then resume at the same idx with the same residual step count.
REQ-038 Bench SHALL cover: ACT_LOW=1 with rst_n pulsed low mid-sweep between clock edges -> dec_out all 1, busy=0 immediately.
